layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
  NUM_STAGES, 3, number of chained conv stages (e.g. depthwise, pointwise, pool); range 1..8
  SETTLE_CYCLES, 2, idle cycles between a stage's done and the next stage's start, for BRAM write flush; 0 allowed
  TIMEOUT_CYCLES, 65536, watchdog limit per stage, in cycles
  CNT_W, 8, frame_count width
REQ-002 Ports (name, direction, width, meaning):
  clk  in  1  clock
  rst_n  in  1  reset, asynchronous, active-low
  run  in  1  one-cycle request to start a frame
  abort  in  1  level/pulse, cancels the frame
  stage_done  in  NUM_STAGES  per-stage done pulse
  stage_start  out  NUM_STAGES  per-stage one-cycle start pulse
  stage_ena  out  NUM_STAGES  one-hot BRAM enable for the owning stage
  cur_stage  out  3  index of the active stage
  busy  out  1  frame in progress
  done  out  1  one-cycle frame-complete pulse
  error  out  1  sticky watchdog error
  err_stage  out  3  stage that timed out
  frame_count  out  CNT_W  completed frames, wraps

Function
REQ-003 FSM states: IDLE, LAUNCH, WAIT, GAP, FINISH, ERROR.
REQ-004 IDLE: busy=0, stage_ena=0; run=1 -> cur_stage=0, error cleared, next LAUNCH.
REQ-005 LAUNCH (exactly 1 cycle): stage_start[cur_stage]=1, stage_ena one-hot at cur_stage, busy=1, next WAIT.
REQ-006 WAIT: stage_ena held; stage_done[cur_stage]=1 -> FINISH if cur_stage==NUM_STAGES-1, else GAP (or LAUNCH with cur_stage+1 when SETTLE_CYCLES==0).
REQ-007 stage_done bits of non-active stages are ignored in every state.
REQ-008 GAP: stage_ena stays on the finishing stage for SETTLE_CYCLES cycles, then cur_stage+1 and LAUNCH.
REQ-009 Latency: run at cycle 0 -> stage_start[0] at cycle 1; stage_done[k] at cycle t -> stage_start[k+1] at t+SETTLE_CYCLES+1.
REQ-010 FINISH (1 cycle): done=1, frame_count+1 (mod 2^CNT_W), stage_ena=0; busy=1 during FINISH and 0 from the next cycle; next IDLE.
REQ-011 run while busy=1 or in FINISH is ignored, with no queuing.
REQ-012 abort=1 in any non-IDLE state -> IDLE next cycle: stage_ena=0, no done, frame_count unchanged; abort wins over a stage_done in the same cycle.
REQ-013 stage_start and stage_ena are never asserted for more than one stage in a cycle.
REQ-014 All outputs are registered.

Reset
REQ-015 rst_n low -> state IDLE; cur_stage=0, stage_start=0, stage_ena=0, busy=0, done=0, error=0, err_stage=0, frame_count=0, watchdog counter=0.
REQ-016 Reset mid-frame discards the frame; the first run after release starts at stage 0.

Configuration
REQ-017 SEQ_WATCHDOG_EN defined: a counter runs in WAIT; TIMEOUT_CYCLES cycles without stage_done[cur_stage] -> ERROR: error=1, err_stage=cur_stage, stage_ena=0, busy=0.
REQ-018 ERROR exits on run (clears error, starts at stage 0) or on abort (to IDLE, error stays set until the next run).
REQ-019 SEQ_WATCHDOG_EN undefined: no counter, ERROR unreachable, error and err_stage tied 0, WAIT waits indefinitely.

Verification (NUM_STAGES=3, SETTLE_CYCLES=2, TIMEOUT_CYCLES=100)
REQ-020 Full frame: run@0, stage_done[0]@10, [1]@20, [2]@30 -> stage_start pulses @1, @13, @23; done@31; frame_count=1; busy low @32.
REQ-021 Spurious done: stage_done[2]@5 while stage 0 is active -> ignored; cur_stage stays 0; stage_ena=3'b001.
REQ-022 Abort race: abort and stage_done[1] both @20 -> IDLE @21, stage_ena=0, no done, no start of stage 2.
REQ-023 Watchdog (SEQ_WATCHDOG_EN): run@0, no stage_done -> error=1 and err_stage=0 by cycle 102; a later run clears error and pulses stage_start[0].
REQ-024 Run while busy: second run@15 of an active frame -> no effect; after 255 frames with 1 extra, frame_count wraps to 0.
REQ-025 Async reset asserted @15 mid-frame -> all outputs 0 immediately; run after release -> stage_start[0] one cycle later.

Source files
------------

// File: rtl/layer_sequencer.sv
// layer_sequencer: launches a chain of conv stages one after another for each
// frame, hands the BRAM enable to the stage that owns it, and inserts settle
// gaps between stages so BRAM writes can flush before the next stage starts.
// Optional feature macro: SEQ_WATCHDOG_EN adds a per-stage watchdog that moves
// the sequencer to an ERROR state when a stage never reports done.
// All outputs come straight from flops. The next-state logic also computes
// next-cycle output values, and these are registered on the same edge as the
// state.
module layer_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CNT_W          = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic [NUM_STAGES-1:0] stage_start,
  output logic [NUM_STAGES-1:0] stage_ena,
  output logic [2:0]            cur_stage,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            err_stage,
  output logic [CNT_W-1:0]      frame_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4,
    ERROR  = 3'd5
  } state_t;

  localparam logic [2:0]            LAST_STAGE = 3'(NUM_STAGES - 1);
  localparam int                    GAP_W      = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GAP_W-1:0]      GAP_LAST   = GAP_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE  = NUM_STAGES'(1);

  state_t                  state, state_next;
  logic [2:0]              cur_next;
  logic [GAP_W-1:0]        gap_cnt, gap_next;
  logic [NUM_STAGES-1:0]   start_next;
  logic [NUM_STAGES-1:0]   ena_next;
  logic                    busy_next;
  logic                    done_next;
  logic [CNT_W-1:0]        count_next;
  logic [NUM_STAGES-1:0]   stage_sel;
  logic                    active_done;

`ifdef SEQ_WATCHDOG_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt, wd_next;
  logic            error_next;
  logic [2:0]      err_stage_next;
`endif

  // Only the done bit of the active stage matters; other stages' bits are masked.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
      assign stage_sel[gi] = (cur_stage == 3'(gi));
    end
  endgenerate

  assign active_done = |(stage_done & stage_sel);

`ifndef SEQ_WATCHDOG_EN
  assign error     = 1'b0;
  assign err_stage = 3'd0;
`endif

  // Next-state logic plus next-cycle values of the registered outputs.
  always_comb begin
    state_next = state;
    cur_next   = cur_stage;
    gap_next   = gap_cnt;
    count_next = frame_count;
    start_next = '0;
    ena_next   = '0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    wd_next        = wd_cnt;
    error_next     = error;
    err_stage_next = err_stage;
`endif

    if (abort && (state != IDLE)) begin
      // Abort beats any stage_done in the same cycle and leaves error as is.
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            cur_next   = 3'd0;
            state_next = LAUNCH;
`ifdef SEQ_WATCHDOG_EN
            error_next = 1'b0;
`endif
          end
        end

        LAUNCH: begin
          state_next = WAIT;
`ifdef SEQ_WATCHDOG_EN
          wd_next    = '0;
`endif
        end

        WAIT: begin
          if (active_done) begin
            if (cur_stage == LAST_STAGE) begin
              state_next = FINISH;
            end else if (SETTLE_CYCLES == 0) begin
              cur_next   = cur_stage + 3'd1;
              state_next = LAUNCH;
            end else begin
              gap_next   = '0;
              state_next = GAP;
            end
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            state_next     = ERROR;
            error_next     = 1'b1;
            err_stage_next = cur_stage;
          end else begin
            wd_next = wd_cnt + WD_W'(1);
          end
`endif
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            cur_next   = cur_stage + 3'd1;
            state_next = LAUNCH;
          end else begin
            gap_next = gap_cnt + GAP_W'(1);
          end
        end

        FINISH: begin
          state_next = IDLE;
        end

        ERROR: begin
          if (run) begin
            cur_next   = 3'd0;
            state_next = LAUNCH;
`ifdef SEQ_WATCHDOG_EN
            error_next = 1'b0;
`endif
          end
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end

    // Output values for the state being entered.
    case (state_next)
      LAUNCH: begin
        start_next = STAGE_ONE << cur_next;
        ena_next   = STAGE_ONE << cur_next;
        busy_next  = 1'b1;
      end
      WAIT: begin
        ena_next  = STAGE_ONE << cur_next;
        busy_next = 1'b1;
      end
      GAP: begin
        // Finishing stage keeps the BRAM while its writes drain.
        ena_next  = STAGE_ONE << cur_stage;
        busy_next = 1'b1;
      end
      FINISH: begin
        done_next  = 1'b1;
        busy_next  = 1'b1;
        count_next = frame_count + CNT_W'(1);
      end
      default: begin
        start_next = '0;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously on rst_n low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_stage   <= 3'd0;
      gap_cnt     <= '0;
      stage_start <= '0;
      stage_ena   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_next;
      cur_stage   <= cur_next;
      gap_cnt     <= gap_next;
      stage_start <= start_next;
      stage_ena   <= ena_next;
      busy        <= busy_next;
      done        <= done_next;
      frame_count <= count_next;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  // Watchdog counter and sticky error status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      error     <= 1'b0;
      err_stage <= 3'd0;
    end else begin
      wd_cnt    <= wd_next;
      error     <= error_next;
      err_stage <= err_stage_next;
    end
  end
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer (3 stages, 2 settle cycles, timeout 100).
// Cycle n is the interval after the n-th rising edge counted from the run pulse;
// inputs are driven and outputs are sampled 1 ns after each rising edge.
module tb_layer_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       abort;
  logic [2:0] stage_done;
  logic [2:0] stage_start;
  logic [2:0] stage_ena;
  logic [2:0] cur_stage;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] err_stage;
  logic [7:0] frame_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  layer_sequencer #(
    .NUM_STAGES    (3),
    .SETTLE_CYCLES (2),
    .TIMEOUT_CYCLES(100),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .abort      (abort),
    .stage_done (stage_done),
    .stage_start(stage_start),
    .stage_ena  (stage_ena),
    .cur_stage  (cur_stage),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_stage  (err_stage),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock; one-cycle request pulses are dropped afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
    run        = 1'b0;
    abort      = 1'b0;
    stage_done = 3'b000;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Complete frame with minimal waits; checks the done pulse at FINISH.
  task automatic do_frame();
    run = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      tick();
      stage_done = 3'b001 << s;
      tick();
      if (s < 2) begin
        tick();
        tick();
      end
    end
    check("frame_done", 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    run        = 1'b0;
    abort      = 1'b0;
    stage_done = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(stage_start), 32'd0);
    check("rst_ena",   32'(stage_ena),   32'd0);
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_done",  32'(done),        32'd0);
    check("rst_error", 32'(error),       32'd0);
    check("rst_count", 32'(frame_count), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Full frame: done[0]@10, [1]@20, [2]@30.
    cyc = 0;
    run = 1'b1;
    tick();
    check("ff_start0", 32'(stage_start), 32'b001);
    check("ff_ena0",   32'(stage_ena),   32'b001);
    check("ff_busy1",  32'(busy),        32'd1);
    tick();
    check("ff_start0_pulse", 32'(stage_start), 32'b000);
    goto(10);
    stage_done = 3'b001;
    tick();
    check("ff_gap_ena",   32'(stage_ena),   32'b001);
    check("ff_gap_start", 32'(stage_start), 32'b000);
    tick();
    check("ff_gap2_start", 32'(stage_start), 32'b000);
    tick();
    check("ff_start1", 32'(stage_start), 32'b010);
    check("ff_cur1",   32'(cur_stage),   32'd1);
    check("ff_ena1",   32'(stage_ena),   32'b010);
    goto(20);
    stage_done = 3'b010;
    goto(23);
    check("ff_start2", 32'(stage_start), 32'b100);
    check("ff_cur2",   32'(cur_stage),   32'd2);
    goto(30);
    stage_done = 3'b100;
    tick();
    check("ff_done",      32'(done),        32'd1);
    check("ff_busy_fin",  32'(busy),        32'd1);
    check("ff_ena_fin",   32'(stage_ena),   32'b000);
    check("ff_count",     32'(frame_count), 32'd1);
    tick();
    check("ff_busy_low",  32'(busy),        32'd0);
    check("ff_done_pulse", 32'(done),       32'd0);

    // Spurious done, run while busy, abort racing stage_done[1].
    tick();
    cyc = 0;
    run = 1'b1;
    tick();
    goto(5);
    stage_done = 3'b100;
    tick();
    check("sp_cur",  32'(cur_stage), 32'd0);
    check("sp_ena",  32'(stage_ena), 32'b001);
    check("sp_busy", 32'(busy),      32'd1);
    goto(10);
    stage_done = 3'b001;
    goto(15);
    run = 1'b1;
    tick();
    check("rb_start", 32'(stage_start), 32'b000);
    check("rb_cur",   32'(cur_stage),   32'd1);
    check("rb_ena",   32'(stage_ena),   32'b010);
    goto(20);
    abort      = 1'b1;
    stage_done = 3'b010;
    tick();
    check("ab_busy", 32'(busy),      32'd0);
    check("ab_ena",  32'(stage_ena), 32'b000);
    check("ab_done", 32'(done),      32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ab_no_start", 32'(stage_start), 32'b000);
      check("ab_no_done",  32'(done),        32'd0);
    end
    check("ab_count", 32'(frame_count), 32'd1);

    // Watchdog: run with no stage_done at all.
    tick();
    cyc = 0;
    run = 1'b1;
    tick();
`ifdef SEQ_WATCHDOG_EN
    goto(101);
    check("wd_pre_error", 32'(error), 32'd0);
    tick();
    check("wd_error",     32'(error),     32'd1);
    check("wd_err_stage", 32'(err_stage), 32'd0);
    check("wd_busy",      32'(busy),      32'd0);
    check("wd_ena",       32'(stage_ena), 32'b000);
    run = 1'b1;
    tick();
    check("wd_clear",   32'(error),       32'd0);
    check("wd_restart", 32'(stage_start), 32'b001);
    abort = 1'b1;
    tick();
    check("wd_abort_busy", 32'(busy), 32'd0);
`else
    goto(102);
    check("nowd_error", 32'(error),     32'd0);
    check("nowd_busy",  32'(busy),      32'd1);
    check("nowd_ena",   32'(stage_ena), 32'b001);
    abort = 1'b1;
    tick();
    check("nowd_abort_busy", 32'(busy), 32'd0);
`endif

    // Asynchronous reset in the middle of stage 1.
    tick();
    cyc = 0;
    run = 1'b1;
    tick();
    goto(10);
    stage_done = 3'b001;
    goto(15);
    check("ar_pre_cur", 32'(cur_stage), 32'd1);
    rst_n = 1'b0;
    #1;
    check("ar_start", 32'(stage_start), 32'd0);
    check("ar_ena",   32'(stage_ena),   32'd0);
    check("ar_busy",  32'(busy),        32'd0);
    check("ar_cur",   32'(cur_stage),   32'd0);
    check("ar_count", 32'(frame_count), 32'd0);
    check("ar_done",  32'(done),        32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cyc = 0;
    run = 1'b1;
    tick();
    check("ar_run_start", 32'(stage_start), 32'b001);
    check("ar_run_cur",   32'(cur_stage),   32'd0);
    abort = 1'b1;
    tick();
    tick();

    // frame_count wrap: 255 frames, then one more.
    for (int f = 0; f < 255; f++) do_frame();
    check("wrap_255", 32'(frame_count), 32'd255);
    do_frame();
    check("wrap_0", 32'(frame_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
